// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, synchronizer depth and default widths.
// Used by both spi_slave and spi_master.
package spi_pkg;

    typedef enum logic [1:0] {
        st_idle,
        st_active,
        st_done
    } spi_state_t;

    localparam int unsigned SyncDepth             = 2;
    localparam int unsigned DefaultMaxDataBuffer  = 64;
    localparam int unsigned DefaultDataIndexWidth = 6;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a third register for edge detection.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic p_reset_level = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SyncDepth-1:0] sync_q;
    logic                 prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SyncDepth{p_reset_level}};
            prev_q <= p_reset_level;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], din};
            prev_q <= sync_q[SyncDepth-1];
        end
    end

    assign level = sync_q[SyncDepth-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, CPHA=0: oversamples sck/mosi/cs_n on clk, shifts a held word out on or_miso
// MSB first while capturing mosi, and reports the received word with a one-cycle pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic        p_cpol            = 1'b0,
    parameter int unsigned p_max_data_buffer = DefaultMaxDataBuffer,
    parameter int unsigned pw_data_index     = DefaultDataIndexWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [p_max_data_buffer-1:0] ip_data,
    input  logic [pw_data_index-1:0]     ip_data_count,
    input  logic                         i_data_valid,
    output logic                         o_data_ready,
    output logic [p_max_data_buffer-1:0] orp_data,
    output logic                         o_rx_valid,
    output logic                         o_frame_error,
    input  logic                         i_sck,
    input  logic                         i_mosi,
    input  logic                         i_cs_n,
    output logic                         or_miso
);

    // One extra bit so the index can equal the largest count without wrapping.
    localparam int unsigned IdxW = pw_data_index + 1;

    spi_state_t state_q, state_d;

    logic [p_max_data_buffer-1:0] tx_hold_q, tx_hold_d;
    logic [p_max_data_buffer-1:0] rx_shift_q, rx_shift_d;
    logic [p_max_data_buffer-1:0] orp_data_q, orp_data_d;
    logic [pw_data_index-1:0]     count_q, count_d;
    logic [IdxW-1:0]              index_q, index_d;
    logic                         miso_q, miso_d;
    logic                         rx_valid_q, rx_valid_d;
    logic                         frame_error_q, frame_error_d;

    logic [IdxW-1:0] count_ext;
    logic [IdxW-1:0] bit_sel;
    logic            tx_bit;
    logic            load;
    logic            last_rise;

    logic sck_raw_rise, sck_raw_fall, sck_level_unused;
    logic sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(
        .p_reset_level(p_cpol)
    ) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .din  (i_sck),
        .level(sck_level_unused),
        .rise (sck_raw_rise),
        .fall (sck_raw_fall)
    );

    spi_sync_edge #(
        .p_reset_level(1'b1)
    ) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (i_cs_n),
        .level(cs_level),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(
        .p_reset_level(1'b0)
    ) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (i_mosi),
        .level(mosi_level),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    // With CPOL=1 the raw falling edge is the logical leading (sampling) edge.
    assign sck_rise = p_cpol ? sck_raw_fall : sck_raw_rise;
    assign sck_fall = p_cpol ? sck_raw_rise : sck_raw_fall;

    assign o_data_ready = (state_q == st_idle) && cs_level;
    assign load         = i_data_valid && o_data_ready && (ip_data_count != '0);

    assign count_ext = IdxW'(count_q);
    assign last_rise = sck_rise && ((index_q + IdxW'(1)) == count_ext);

    // Next bit to drive: count-1 at frame start, count-1-index while shifting.
    always_comb begin
        bit_sel = count_ext - IdxW'(1);
        if (state_q == st_active) begin
            bit_sel = bit_sel - index_q;
        end
        tx_bit = 1'b0;
        for (int unsigned i = 0; i < p_max_data_buffer; i++) begin
            if (bit_sel == IdxW'(i)) begin
                tx_bit = tx_hold_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_hold_d     = load ? ip_data : tx_hold_q;
        count_d       = load ? ip_data_count : count_q;
        index_d       = index_q;
        rx_shift_d    = rx_shift_q;
        orp_data_d    = orp_data_q;
        miso_d        = miso_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            st_idle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d    = st_active;
                    index_d    = '0;
                    rx_shift_d = '0;
                    miso_d     = tx_bit;
                end
            end
            st_active: begin
                if (index_q == count_ext) begin
                    orp_data_d = rx_shift_q;
                    rx_valid_d = 1'b1;
                    miso_d     = 1'b0;
                    state_d    = st_done;
                end else if (cs_rise && !last_rise) begin
                    frame_error_d = 1'b1;
                    miso_d        = 1'b0;
                    state_d       = st_idle;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[p_max_data_buffer-2:0], mosi_level};
                    index_d    = index_q + IdxW'(1);
                end else if (sck_fall) begin
                    miso_d = tx_bit;
                end
            end
            st_done: begin
                miso_d = 1'b0;
                // Level, not edge: cs_n may already have risen alongside the final sck edge.
                if (cs_level) begin
                    state_d = st_idle;
                end
            end
            default: begin
                miso_d  = 1'b0;
                state_d = st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= st_idle;
            tx_hold_q     <= '0;
            count_q       <= '0;
            index_q       <= '0;
            rx_shift_q    <= '0;
            orp_data_q    <= '0;
            miso_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_hold_q     <= tx_hold_d;
            count_q       <= count_d;
            index_q       <= index_d;
            rx_shift_q    <= rx_shift_d;
            orp_data_q    <= orp_data_d;
            miso_q        <= miso_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign orp_data      = orp_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_frame_error = frame_error_q;
    assign or_miso       = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one CPOL=0 and one CPOL=1 instance driven by the same master waveform.
module tb_spi_slave;

    localparam int Half = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] ip_data = '0;
    logic [5:0]  ip_data_count = '0;
    logic        i_data_valid = 1'b0;
    logic        sck = 1'b0;
    logic        sck_n;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;

    logic        ready0, ready1, rxv0, rxv1, err0, err1, miso0, miso1;
    logic [63:0] orp0, orp1;

    assign sck_n = ~sck;

    spi_slave #(.p_cpol(1'b0), .p_max_data_buffer(64), .pw_data_index(6)) u_dut0 (
        .clk(clk), .rst(rst), .ip_data(ip_data), .ip_data_count(ip_data_count),
        .i_data_valid(i_data_valid), .o_data_ready(ready0), .orp_data(orp0),
        .o_rx_valid(rxv0), .o_frame_error(err0), .i_sck(sck), .i_mosi(mosi),
        .i_cs_n(cs_n), .or_miso(miso0)
    );

    spi_slave #(.p_cpol(1'b1), .p_max_data_buffer(64), .pw_data_index(6)) u_dut1 (
        .clk(clk), .rst(rst), .ip_data(ip_data), .ip_data_count(ip_data_count),
        .i_data_valid(i_data_valid), .o_data_ready(ready1), .orp_data(orp1),
        .o_rx_valid(rxv1), .o_frame_error(err1), .i_sck(sck_n), .i_mosi(mosi),
        .i_cs_n(cs_n), .or_miso(miso1)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: expected received word and the cycles at which the pulses must appear.
    bit          cmp_en = 1'b0;
    int          valid_at = -1;
    int          err_at = -1;
    logic [63:0] exp_orp = '0;
    logic [63:0] pend_orp = '0;
    int          vcnt0 = 0, vcnt1 = 0, ecnt0 = 0, ecnt1 = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rst_seen) begin
                exp_orp  = '0;
                valid_at = -1;
                err_at   = -1;
                check("rst_miso0", 64'(miso0), 64'd0);
                check("rst_miso1", 64'(miso1), 64'd0);
            end
            if (cyc == valid_at) exp_orp = pend_orp;
            check("orp0", orp0, exp_orp);
            check("orp1", orp1, exp_orp);
            check("rx_valid0", 64'(rxv0), 64'(cyc == valid_at));
            check("rx_valid1", 64'(rxv1), 64'(cyc == valid_at));
            check("frame_err0", 64'(err0), 64'(cyc == err_at));
            check("frame_err1", 64'(err1), 64'(cyc == err_at));
            if (rxv0) vcnt0++;
            if (rxv1) vcnt1++;
            if (err0) ecnt0++;
            if (err1) ecnt1++;
        end
    end

    task automatic load(input logic [63:0] d, input logic [5:0] n);
        @(posedge clk); #1;
        ip_data       = d;
        ip_data_count = n;
        i_data_valid  = 1'b1;
        check("ready0_at_load", 64'(ready0), 64'd1);
        check("ready1_at_load", 64'(ready1), 64'd1);
        @(posedge clk); #1;
        i_data_valid = 1'b0;
    endtask

    // Master: CPHA=0, MSB first, samples miso just before each leading edge.
    task automatic frame(input int nbits, input logic [63:0] mo, input int stop_after,
                         input int extra, input bit do_rst,
                         output logic [63:0] got0, output logic [63:0] got1);
        int nb;
        nb   = (stop_after < nbits) ? stop_after : nbits;
        got0 = '0;
        got1 = '0;
        @(posedge clk); #1;
        cs_n = 1'b0;
        mosi = mo[nbits-1];
        repeat (Half) @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            got0 = {got0[62:0], miso0};
            got1 = {got1[62:0], miso1};
            sck  = 1'b1;
            if (i == nbits - 1) begin
                valid_at = cyc + 4;
                pend_orp = mo & ((64'd1 << nbits) - 64'd1);
            end
            repeat (Half) @(posedge clk); #1;
            sck = 1'b0;
            if (i < nbits - 1) mosi = mo[nbits-2-i];
            repeat (Half) @(posedge clk); #1;
        end
        for (int i = 0; i < extra; i++) begin
            check("extra_miso0", 64'(miso0), 64'd0);
            check("extra_miso1", 64'(miso1), 64'd0);
            sck = 1'b1;
            repeat (Half) @(posedge clk); #1;
            sck = 1'b0;
            repeat (Half) @(posedge clk); #1;
        end
        if (do_rst) begin
            rst  = 1'b1;
            cs_n = 1'b1;
            repeat (5) @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            cs_n = 1'b1;
            if (nb < nbits) err_at = cyc + 3;
        end
        repeat (2 * Half) @(posedge clk); #1;
    endtask

    logic [63:0] g0, g1;
    int v0, v1, e0, e1;

    task automatic snap();
        v0 = vcnt0; v1 = vcnt1; e0 = ecnt0; e1 = ecnt1;
    endtask

    task automatic check_counts(input string name, input int dv, input int de);
        check({name, "_valid0"}, 64'(vcnt0 - v0), 64'(dv));
        check({name, "_valid1"}, 64'(vcnt1 - v1), 64'(dv));
        check({name, "_err0"}, 64'(ecnt0 - e0), 64'(de));
        check({name, "_err1"}, 64'(ecnt1 - e1), 64'(de));
    endtask

    initial begin
        repeat (4) @(posedge clk); #1;
        cmp_en = 1'b1;
        check("reset_ready0", 64'(ready0), 64'd1);
        check("reset_orp0", orp0, 64'd0);
        check("reset_miso0", 64'(miso0), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Basic 8-bit exchange.
        snap();
        load(64'hA5, 6'd8);
        frame(8, 64'h3C, 99, 0, 1'b0, g0, g1);
        check("t1_master0", g0, 64'hA5);
        check("t1_master1", g1, 64'hA5);
        check("t1_orp", orp0, 64'h3C);
        check_counts("t1", 1, 0);

        // 16-bit exchange.
        snap();
        load(64'hBEEF, 6'd16);
        frame(16, 64'h1234, 99, 0, 1'b0, g0, g1);
        check("t2_master0", g0, 64'hBEEF);
        check("t2_master1", g1, 64'hBEEF);
        check("t2_orp1", orp1, 64'h1234);
        check_counts("t2", 1, 0);

        // Abort after 5 of 8 bits.
        snap();
        load(64'hA5, 6'd8);
        frame(8, 64'hFF, 5, 0, 1'b0, g0, g1);
        check("t3_orp_kept", orp0, 64'h1234);
        check("t3_ready0", 64'(ready0), 64'd1);
        check("t3_ready1", 64'(ready1), 64'd1);
        check_counts("t3", 0, 1);

        // Extra sck pulses after a completed frame are ignored.
        snap();
        frame(8, 64'h5A, 99, 10, 1'b0, g0, g1);
        check("t4_master0", g0, 64'hA5);
        check("t4_orp", orp0, 64'h5A);
        check_counts("t4", 1, 0);

        // Zero-count load is ignored; the held word is resent twice.
        snap();
        load(64'hFF, 6'd0);
        frame(8, 64'h11, 99, 0, 1'b0, g0, g1);
        check("t5a_master0", g0, 64'hA5);
        check("t5a_master1", g1, 64'hA5);
        frame(8, 64'h22, 99, 0, 1'b0, g0, g1);
        check("t5b_master0", g0, 64'hA5);
        check("t5b_orp", orp0, 64'h22);
        check_counts("t5", 2, 0);

        // Reset at bit 3, then a fresh frame.
        snap();
        frame(8, 64'h77, 3, 0, 1'b1, g0, g1);
        check("t6_orp_reset", orp0, 64'd0);
        check("t6_ready0", 64'(ready0), 64'd1);
        check_counts("t6rst", 0, 0);
        snap();
        load(64'hC3, 6'd8);
        frame(8, 64'h96, 99, 0, 1'b0, g0, g1);
        check("t6_master0", g0, 64'hC3);
        check("t6_master1", g1, 64'hC3);
        check("t6_orp", orp1, 64'h96);
        check_counts("t6", 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the team's SPI master. Runs on the system clock and oversamples the external i_sck, i_mosi and i_cs_n.
- Shifts out a preloaded transmit word on or_miso while shifting in i_mosi, MSB first, for a programmable bit count.
- Presents the received word with a one-cycle valid pulse.
- Used in peripheral-side models and FPGA targets that must answer the SPI master.

Parameters:
- p_cpol, 0, clock polarity; 1 means i_sck is inverted before use. Mode is CPHA=0 in both cases.
- p_max_data_buffer, 64, width of the transmit and receive data buffers.
- pw_data_index, 6, width of the bit count and bit index.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ip_data  input  p_max_data_buffer  word to transmit, right-aligned; bit [count-1] is sent first
- ip_data_count  input  pw_data_index  number of bits per frame, 1..2^pw_data_index-1
- i_data_valid  input  1  load request for ip_data and ip_data_count
- o_data_ready  output  1  high when a load is accepted this cycle
- orp_data  output  p_max_data_buffer  last received word, right-aligned, upper bits zero
- o_rx_valid  output  1  one-cycle pulse when orp_data updates
- o_frame_error  output  1  one-cycle pulse when a frame aborts early
- i_sck  input  1  SPI clock from master, asynchronous
- i_mosi  input  1  master-out data, asynchronous
- i_cs_n  input  1  active-low chip select, asynchronous
- or_miso  output  1  slave-out data, registered

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: or_miso=0, orp_data=0, o_rx_valid=0, o_frame_error=0, state=st_idle, tx hold=0, count hold=0, all synchronizers cleared to their idle level (i_cs_n path to 1, i_sck path to p_cpol).
- Synchronization: i_sck, i_mosi and i_cs_n each pass through a 2-flop synchronizer. A third register on sck and cs_n provides edge detection.
  - Required timing: i_sck high and low phases are each at least 4 clk cycles.
  - The i_sck rise and fall used below are taken after p_cpol correction.
- o_data_ready = (state==st_idle) && synced cs_n==1.
  - A load happens when i_data_valid && o_data_ready && ip_data_count!=0. It captures ip_data and ip_data_count.
  - A load with count 0 is ignored: no state change, the previous hold values are kept.
- States:
  - st_idle: or_miso=0. Synced cs_n falling edge -> st_active. In the same cycle: bit index=0, rx shift register cleared, or_miso <= tx_hold[count-1].
  - st_active:
    - On a synced sck rising edge: rx shift <= {rx shift, synced mosi}; index <= index+1.
    - On a synced sck falling edge with index<count: or_miso <= tx_hold[count-1-index].
    - When index reaches count, on the cycle after the last rising edge: orp_data <= rx shift (upper bits zero), o_rx_valid=1 for one cycle, or_miso <= 0, go to st_done.
  - st_done: all sck edges are ignored and or_miso stays 0. Synced cs_n rising edge -> st_idle.
- Abort: a synced cs_n rising edge in st_active with index<count -> st_idle, o_frame_error=1 for one cycle, orp_data unchanged, no o_rx_valid.
- Simultaneous events: a cs_n rising edge and the completing sck edge in the same cycle count as completion (o_rx_valid, no error).
- Re-arm: tx_hold is not consumed by a frame. A second frame without a reload resends the same word.
- Latency: o_rx_valid asserts 4 clk cycles after the final i_sck rising edge at the pin (2 sync + 1 edge detect + 1 output register). or_miso changes 3 clk cycles after an i_sck falling edge.
- Reset mid-frame: the frame is abandoned silently (no error pulse) and outputs return to reset values.
- Width rule: index is pw_data_index+1 bits wide so it compares against count without wrap.

Decomposition:
- Shared package spi_pkg holds the state encodings st_idle, st_active, st_done, the synchronizer depth constant (2) and the default buffer/index widths, shared with spi_master.
- One natural sub-module, spi_sync_edge: a 2-flop synchronizer plus edge detector. Parameter for reset level; outputs level, rise and fall. Instantiated three times; only level is used for mosi.

Test Plan:
- Mode 0, master prescaler 25, load tx=8'hA5, count=8; master sends 8'h3C -> master receives 8'hA5; orp_data=64'h3C; one o_rx_valid pulse; no o_frame_error.
- p_cpol=1, count=16, tx=16'hBEEF, mosi=16'h1234 -> master receives 16'hBEEF; orp_data=16'h1234.
- cs_n deasserted after 5 of 8 bits -> o_frame_error pulses once; orp_data keeps its prior value; o_data_ready returns to 1.
- 10 extra sck pulses after an 8-bit frame with cs_n still low -> or_miso stays 0; no second o_rx_valid.
- Load with count=0 -> ignored, hold keeps the previous 8'hA5/8. Then two frames without a reload -> 8'hA5 sent twice.
- rst asserted at bit 3 -> all outputs are at reset values the next cycle; no error pulse. The next full frame works normally.
